// File: rtl/motion_update_broadcaster.sv
// -----------------------------------------------------------------------------
// motion_update_broadcaster
//
// Transmitting end of the motion-update broadcast bus. Sweeps every cell of the
// grid in x, y, z order (z fastest), reads the particle count at address 0 of
// the cell's active cache buffer, then reads each particle record and
// broadcasts it together with the cell it now belongs to. The receiving caches
// capture particles while out_motion_update_enable is high and commit their
// counts / flip buffers when it falls; out_done pulses once they have had time
// to do so.
//
// Ports
//   clk                       system clock
//   rst                       asynchronous, active-high reset
//   start                     one-cycle sweep request, honoured only in IDLE
//   in_particle_info          cache read data, valid one cycle after out_rden
//   out_read_cell_id          cache select {x, y, z} for the readout mux
//   out_read_address          cache read address (0 = particle count)
//   out_rden                  cache read enable
//   out_motion_update_enable  high for the whole sweep
//   out_data                  broadcast particle record {posz, posy, posx}
//   out_data_dst_cell         destination cell {x, y, z}
//   out_data_valid            broadcast qualifier
//   out_done                  one-cycle pulse when the sweep is complete
// -----------------------------------------------------------------------------
module motion_update_broadcaster #(
  parameter int DATA_WIDTH    = 96,
  parameter int POS_WIDTH     = 32,
  parameter int FRAC_WIDTH    = 28,
  parameter int ADDR_WIDTH    = 8,
  parameter int PARTICLE_NUM  = 220,
  parameter int CELL_ID_WIDTH = 4,
  parameter int CELL_MAX_X    = 3,
  parameter int CELL_MAX_Y    = 3,
  parameter int CELL_MAX_Z    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DATA_WIDTH-1:0]      in_particle_info,
  output logic [3*CELL_ID_WIDTH-1:0] out_read_cell_id,
  output logic [ADDR_WIDTH-1:0]      out_read_address,
  output logic                       out_rden,
  output logic                       out_motion_update_enable,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic                       out_done
);

  typedef enum logic [2:0] {
    IDLE,
    RD_NUM,
    WAIT_NUM,
    RD_PART,
    NEXT_CELL,
    DRAIN
  } state_e;

  localparam logic [CELL_ID_WIDTH-1:0] MAX_X    = CELL_ID_WIDTH'(CELL_MAX_X);
  localparam logic [CELL_ID_WIDTH-1:0] MAX_Y    = CELL_ID_WIDTH'(CELL_MAX_Y);
  localparam logic [CELL_ID_WIDTH-1:0] MAX_Z    = CELL_ID_WIDTH'(CELL_MAX_Z);
  localparam logic [CELL_ID_WIDTH-1:0] CELL_ONE = CELL_ID_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]    COUNT_MAX = ADDR_WIDTH'(PARTICLE_NUM);
  localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE  = ADDR_WIDTH'(1);
  // Enable stays low for three cycles before done: the counter walks 0,1,2
  // and done is registered out of the last step.
  localparam logic [1:0]               DRAIN_LAST = 2'd2;

  // Periodic-boundary mapping of one position component to a cell coordinate.
  function automatic logic [CELL_ID_WIDTH-1:0] dst_axis(
    input logic [POS_WIDTH-1:0]     pos,
    input logic [CELL_ID_WIDTH-1:0] cell_max
  );
    logic [CELL_ID_WIDTH-1:0] idx;
    idx = CELL_ID_WIDTH'(pos >> FRAC_WIDTH);
    if (idx == '0) begin
      dst_axis = cell_max;
    end else if (idx > cell_max) begin
      dst_axis = CELL_ONE;
    end else begin
      dst_axis = idx;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                     state_q, state_d;
  logic [CELL_ID_WIDTH-1:0]   cell_x_q, cell_x_d;
  logic [CELL_ID_WIDTH-1:0]   cell_y_q, cell_y_d;
  logic [CELL_ID_WIDTH-1:0]   cell_z_q, cell_z_d;
  logic [ADDR_WIDTH-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0]      k_q, k_d;
  logic                       enable_q, enable_d;
  logic [1:0]                 drain_cnt_q, drain_cnt_d;
  logic                       done_q, done_d;

  // Broadcast pipeline: rd_pend_q marks that the data arriving this cycle
  // belongs to a particle read (not a count read).
  logic                       rd_pend_q, rd_pend_d;
  logic                       valid_q, valid_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [3*CELL_ID_WIDTH-1:0] dst_q, dst_d;

  // Combinational read-port outputs
  logic [3*CELL_ID_WIDTH-1:0] read_cell_id;
  logic [ADDR_WIDTH-1:0]      read_address;
  logic                       rden;

  // ---------------------------------------------------------------------------
  // Read-data decode
  // ---------------------------------------------------------------------------
  logic [POS_WIDTH-1:0]  pos_x, pos_y, pos_z;
  logic [ADDR_WIDTH-1:0] raw_count, clamped_count;
  logic                  last_cell;
  logic                  pipe_empty;

  assign pos_x = in_particle_info[POS_WIDTH-1:0];
  assign pos_y = in_particle_info[2*POS_WIDTH-1:POS_WIDTH];
  assign pos_z = in_particle_info[3*POS_WIDTH-1:2*POS_WIDTH];

  assign raw_count     = in_particle_info[ADDR_WIDTH-1:0];
  assign clamped_count = (raw_count > COUNT_MAX) ? COUNT_MAX : raw_count;

  assign last_cell  = (cell_x_q == MAX_X) && (cell_y_q == MAX_Y) && (cell_z_q == MAX_Z);
  assign pipe_empty = !rd_pend_q && !valid_q;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch of the
    // case can leave one unassigned and infer a latch.
    state_d      = state_q;
    cell_x_d     = cell_x_q;
    cell_y_d     = cell_y_q;
    cell_z_d     = cell_z_q;
    count_d      = count_q;
    k_d          = k_q;
    enable_d     = enable_q;
    drain_cnt_d  = drain_cnt_q;
    done_d       = 1'b0;
    rd_pend_d    = 1'b0;
    read_cell_id = '0;
    read_address = '0;
    rden         = 1'b0;

    // Second pipeline stage: register the returned record and its destination.
    // The bus is forced to zero whenever it carries no particle.
    valid_d = rd_pend_q;
    data_d  = rd_pend_q ? in_particle_info : '0;
    dst_d   = rd_pend_q ? {dst_axis(pos_x, MAX_X),
                           dst_axis(pos_y, MAX_Y),
                           dst_axis(pos_z, MAX_Z)} : '0;

    case (state_q)
      IDLE: begin
        // A start that coincides with the done pulse belongs to the sweep that
        // is just ending and is dropped.
        if (start && !done_q) begin
          enable_d = 1'b1;
          cell_x_d = CELL_ONE;
          cell_y_d = CELL_ONE;
          cell_z_d = CELL_ONE;
          state_d  = RD_NUM;
        end
      end

      RD_NUM: begin
        read_cell_id = {cell_x_q, cell_y_q, cell_z_q};
        read_address = '0;
        rden         = 1'b1;
        state_d      = WAIT_NUM;
      end

      WAIT_NUM: begin
        read_cell_id = {cell_x_q, cell_y_q, cell_z_q};
        count_d      = clamped_count;
        k_d          = ADDR_ONE;
        state_d      = (clamped_count == '0) ? NEXT_CELL : RD_PART;
      end

      RD_PART: begin
        read_cell_id = {cell_x_q, cell_y_q, cell_z_q};
        read_address = k_q;
        rden         = 1'b1;
        rd_pend_d    = 1'b1;
        if (k_q == count_q) begin
          state_d = NEXT_CELL;
        end else begin
          k_d = k_q + ADDR_ONE;
        end
      end

      NEXT_CELL: begin
        // z fastest, then y, then x; every coordinate wraps back to 1.
        if (cell_z_q == MAX_Z) begin
          cell_z_d = CELL_ONE;
          if (cell_y_q == MAX_Y) begin
            cell_y_d = CELL_ONE;
            cell_x_d = (cell_x_q == MAX_X) ? CELL_ONE : cell_x_q + CELL_ONE;
          end else begin
            cell_y_d = cell_y_q + CELL_ONE;
          end
        end else begin
          cell_z_d = cell_z_q + CELL_ONE;
        end
        drain_cnt_d = '0;
        state_d     = last_cell ? DRAIN : RD_NUM;
      end

      DRAIN: begin
        if (enable_q) begin
          // Hold enable until the last particle has left the bus, so the
          // caches see enable fall only after their final capture.
          if (pipe_empty) begin
            enable_d = 1'b0;
          end
        end else if (drain_cnt_q == DRAIN_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cell_x_q    <= CELL_ONE;
      cell_y_q    <= CELL_ONE;
      cell_z_q    <= CELL_ONE;
      count_q     <= '0;
      k_q         <= '0;
      enable_q    <= 1'b0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      dst_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values
      // from before this edge regardless of statement order.
      state_q     <= state_d;
      cell_x_q    <= cell_x_d;
      cell_y_q    <= cell_y_d;
      cell_z_q    <= cell_z_d;
      count_q     <= count_d;
      k_q         <= k_d;
      enable_q    <= enable_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      rd_pend_q   <= rd_pend_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      dst_q       <= dst_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_read_cell_id         = read_cell_id;
  assign out_read_address         = read_address;
  assign out_rden                 = rden;
  assign out_motion_update_enable = enable_q;
  assign out_data                 = data_q;
  assign out_data_dst_cell        = dst_q;
  assign out_data_valid           = valid_q;
  assign out_done                 = done_q;

endmodule

// File: tb/tb_motion_update_broadcaster.sv
// -----------------------------------------------------------------------------
// Testbench for motion_update_broadcaster.
// A behavioural cache array answers reads one cycle later; a bus monitor
// records every broadcast, read and control event; each test task builds the
// expected broadcast list from the cache contents and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_motion_update_broadcaster;

  localparam int DW    = 96;
  localparam int AW    = 8;
  localparam int NCELL = 27;
  localparam int CAP   = 220;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] in_particle_info = '0;
  logic [11:0]   out_read_cell_id;
  logic [AW-1:0] out_read_address;
  logic          out_rden;
  logic          out_motion_update_enable;
  logic [DW-1:0] out_data;
  logic [11:0]   out_data_dst_cell;
  logic          out_data_valid;
  logic          out_done;

  motion_update_broadcaster dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .in_particle_info         (in_particle_info),
    .out_read_cell_id         (out_read_cell_id),
    .out_read_address         (out_read_address),
    .out_rden                 (out_rden),
    .out_motion_update_enable (out_motion_update_enable),
    .out_data                 (out_data),
    .out_data_dst_cell        (out_data_dst_cell),
    .out_data_valid           (out_data_valid),
    .out_done                 (out_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Cache contents, one 256-entry buffer per cell (cell index = (x-1)*9+(y-1)*3+(z-1)).
  logic [DW-1:0] mem [NCELL][256];

  // Monitor records (appended only by the monitor)
  logic [DW-1:0] obs_data[$];
  logic [11:0]   obs_dst[$];
  int            obs_cyc[$];
  int            rd_cyc[$];
  int            rd_cnt[NCELL];
  int            viol = 0;
  int            done_n = 0;
  int            done_cyc = 0;
  int            fall_cyc = 0;
  int            en_cycles = 0;
  int            cyc = 0;

  // Reference model output
  logic [DW-1:0] exp_data[$];
  logic [11:0]   exp_dst[$];
  int            exp_cell[$];
  int            exp_cnt[NCELL];

  function automatic int cell_of(input logic [11:0] id);
    int x, y, z;
    x = int'(id[11:8]);
    y = int'(id[7:4]);
    z = int'(id[3:0]);
    if (x < 1 || x > 3 || y < 1 || y > 3 || z < 1 || z > 3) return -1;
    return (x - 1) * 9 + (y - 1) * 3 + (z - 1);
  endfunction

  // Position -> cell coordinate with periodic wrap, in plain arithmetic.
  function automatic int axis_dst(input logic [31:0] p);
    int i;
    i = int'(p / 32'h1000_0000) % 16;
    if (i == 0) return 3;
    if (i > 3) return 1;
    return i;
  endfunction

  // Behavioural cache array: request seen in cycle t, data presented in t+1.
  initial begin : cache_model
    logic          req;
    int            rc;
    logic [AW-1:0] ra;
    forever begin
      @(negedge clk);
      req = out_rden;
      rc  = cell_of(out_read_cell_id);
      ra  = out_read_address;
      @(posedge clk);
      #1;
      if (req && rc >= 0) in_particle_info = mem[rc][ra];
      else                in_particle_info = {$urandom, $urandom, $urandom};
    end
  end

  // Bus monitor, sampled mid-cycle.
  initial begin : bus_monitor
    bit prev_en, prev_valid;
    int c;
    prev_en = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_en = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (out_data_valid) begin
          obs_data.push_back(out_data);
          obs_dst.push_back(out_data_dst_cell);
          obs_cyc.push_back(cyc);
          if (!out_motion_update_enable || !prev_en) viol++;
        end else if (out_data !== '0 || out_data_dst_cell !== '0) begin
          viol++;
        end
        if (!out_motion_update_enable && prev_valid) viol++;
        if (out_motion_update_enable) en_cycles++;
        if (prev_en && !out_motion_update_enable) fall_cyc = cyc;
        if (out_done) begin
          done_n++;
          done_cyc = cyc;
        end
        if (out_rden && out_read_address != '0) begin
          rd_cyc.push_back(cyc);
          c = cell_of(out_read_cell_id);
          if (c >= 0) rd_cnt[c]++;
        end
        prev_en    = out_motion_update_enable;
        prev_valid = out_data_valid;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic clear_mem();
    for (int c = 0; c < NCELL; c++)
      for (int a = 0; a < 256; a++) mem[c][a] = '0;
  endtask

  // Count word carries random upper bits; only its low byte is the count.
  task automatic fill_cells(input int min_n, input int max_n);
    logic [DW-1:0] w;
    int n;
    clear_mem();
    for (int c = 0; c < NCELL; c++) begin
      n = $urandom_range(max_n, min_n);
      w = {$urandom, $urandom, $urandom};
      w[7:0] = 8'(n);
      mem[c][0] = w;
      for (int k = 1; k <= n; k++) mem[c][k] = {$urandom, $urandom, $urandom};
    end
  endtask

  task automatic build_model();
    int c, n, dx, dy, dz;
    logic [DW-1:0] d;
    exp_data.delete();
    exp_dst.delete();
    exp_cell.delete();
    for (int i = 0; i < NCELL; i++) exp_cnt[i] = 0;
    for (int x = 1; x <= 3; x++)
      for (int y = 1; y <= 3; y++)
        for (int z = 1; z <= 3; z++) begin
          c = (x - 1) * 9 + (y - 1) * 3 + (z - 1);
          n = int'(mem[c][0][7:0]);
          if (n > CAP) n = CAP;
          for (int k = 1; k <= n; k++) begin
            d  = mem[c][k];
            dx = axis_dst(d[31:0]);
            dy = axis_dst(d[63:32]);
            dz = axis_dst(d[95:64]);
            exp_data.push_back(d);
            exp_dst.push_back({4'(dx), 4'(dy), 4'(dz)});
            exp_cell.push_back(c);
            exp_cnt[(dx - 1) * 9 + (dy - 1) * 3 + (dz - 1)]++;
          end
        end
  endtask

  // Pulse start, optionally pulse it again mid-sweep (mid_at > 0) and/or on
  // the done cycle, wait for done within a cycle budget, then idle 8 cycles.
  task automatic run_sweep(input int mid_at, input bit start_on_done, output bit timed_out);
    timed_out = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 20000; n++) begin
      @(negedge clk);
      start = (n == mid_at);
      if (out_done) begin
        timed_out = 1'b0;
        if (start_on_done) start = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (out_motion_update_enable !== 1'b0) begin bad++; $display("FAIL reset_enable: got %b want 0", out_motion_update_enable); end
    total++; if (out_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_data_valid); end
    total++; if (out_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", out_done); end
    total++; if (out_rden !== 1'b0) begin bad++; $display("FAIL reset_rden: got %b want 0", out_rden); end
    total++; if (out_read_address !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", out_read_address); end
    total++; if (out_read_cell_id !== '0) begin bad++; $display("FAIL reset_cell_id: got %h want 0", out_read_cell_id); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
    total++; if (out_data_dst_cell !== '0) begin bad++; $display("FAIL reset_dst: got %h want 0", out_data_dst_cell); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out_motion_update_enable !== 1'b0) begin bad++; $display("FAIL idle_enable: got %b want 0", out_motion_update_enable); end
  endtask

  task automatic test_basic();
    int b0, r0, d0, v0, rd112, n111, n211, nb;
    bit to;
    clear_mem();
    mem[0][0] = 96'd2;
    mem[0][1] = {32'h1000_0000, 32'h1000_0000, 32'h1800_0000};
    mem[0][2] = {32'h1000_0000, 32'h1000_0000, 32'h2000_0000};
    b0 = obs_data.size(); r0 = rd_cyc.size(); d0 = done_n; v0 = viol; rd112 = rd_cnt[1];
    run_sweep(0, 1'b0, to);
    nb = obs_data.size() - b0;
    total++; if (to) begin bad++; $display("FAIL basic_timeout: done not seen within budget"); end
    total++; if (nb != 2) begin bad++; $display("FAIL basic_count: got %0d valids want 2", nb); end
    if (nb >= 2) begin
      total++; if (obs_dst[b0] !== 12'h111) begin bad++; $display("FAIL basic_dst0: got %h want 111", obs_dst[b0]); end
      total++; if (obs_dst[b0+1] !== 12'h211) begin bad++; $display("FAIL basic_dst1: got %h want 211", obs_dst[b0+1]); end
      total++; if (obs_data[b0] !== mem[0][1] || obs_data[b0+1] !== mem[0][2]) begin
        bad++; $display("FAIL basic_data: got %h %h want %h %h", obs_data[b0], obs_data[b0+1], mem[0][1], mem[0][2]);
      end
      total++; if (obs_cyc[b0+1] - obs_cyc[b0] != 1) begin bad++; $display("FAIL basic_consecutive: gap %0d want 1", obs_cyc[b0+1] - obs_cyc[b0]); end
      if (rd_cyc.size() > r0) begin
        total++; if (obs_cyc[b0] - rd_cyc[r0] != 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", obs_cyc[b0] - rd_cyc[r0]); end
      end
    end
    n111 = 0; n211 = 0;
    for (int i = b0; i < obs_dst.size(); i++) begin
      if (obs_dst[i] == 12'h111) n111++;
      if (obs_dst[i] == 12'h211) n211++;
    end
    total++; if (n111 != 1 || n211 != 1) begin bad++; $display("FAIL basic_cache_counts: got %0d/%0d want 1/1", n111, n211); end
    total++; if (rd_cyc.size() - r0 != 2) begin bad++; $display("FAIL basic_reads: got %0d want 2", rd_cyc.size() - r0); end
    total++; if (rd_cnt[1] - rd112 != 0) begin bad++; $display("FAIL empty_cell_reads: got %0d want 0", rd_cnt[1] - rd112); end
    total++; if (done_n - d0 != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_n - d0); end
    total++; if (done_cyc - fall_cyc != 3) begin bad++; $display("FAIL basic_done_delay: got %0d want 3", done_cyc - fall_cyc); end
    total++; if (viol != v0) begin bad++; $display("FAIL basic_bus_rules: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_wrap();
    int b0, nb;
    bit to;
    clear_mem();
    mem[15][0] = 96'd2;  // cell (2,3,1)
    mem[15][1] = {32'h1000_0000, 32'h4000_0000, 32'h0800_0000};
    mem[15][2] = {32'h0800_0000, 32'h0800_0000, 32'h4000_0000};
    b0 = obs_data.size();
    run_sweep(0, 1'b0, to);
    nb = obs_data.size() - b0;
    total++; if (to || nb != 2) begin bad++; $display("FAIL wrap_count: got %0d valids timeout=%0d want 2", nb, to); end
    if (nb >= 2) begin
      total++; if (obs_dst[b0] !== 12'h311) begin bad++; $display("FAIL wrap_dst0: got %h want 311", obs_dst[b0]); end
      total++; if (obs_dst[b0+1] !== 12'h133) begin bad++; $display("FAIL wrap_dst1: got %h want 133", obs_dst[b0+1]); end
    end
  endtask

  task automatic test_empty_grid();
    int b0, r0, d0, e0;
    bit to;
    clear_mem();
    b0 = obs_data.size(); r0 = rd_cyc.size(); d0 = done_n; e0 = en_cycles;
    run_sweep(0, 1'b0, to);
    total++; if (to) begin bad++; $display("FAIL empty_timeout: done not seen within budget"); end
    total++; if (obs_data.size() != b0) begin bad++; $display("FAIL empty_valids: got %0d want 0", obs_data.size() - b0); end
    total++; if (rd_cyc.size() != r0) begin bad++; $display("FAIL empty_reads: got %0d want 0", rd_cyc.size() - r0); end
    total++; if (done_n - d0 != 1) begin bad++; $display("FAIL empty_done: got %0d want 1", done_n - d0); end
    total++; if (en_cycles - e0 < 81) begin bad++; $display("FAIL empty_enable_window: got %0d cycles want >=81", en_cycles - e0); end
  endtask

  task automatic test_full_grid();
    int b0, d0, v0, nb, gap, want;
    int obs_cnt[NCELL];
    bit to;
    fill_cells(5, 5);
    build_model();
    b0 = obs_data.size(); d0 = done_n; v0 = viol;
    run_sweep(0, 1'b0, to);
    nb = obs_data.size() - b0;
    total++; if (to) begin bad++; $display("FAIL grid_timeout: done not seen within budget"); end
    total++; if (nb != 135 || exp_data.size() != 135) begin bad++; $display("FAIL grid_count: got %0d want 135", nb); end
    for (int i = 0; i < exp_data.size() && i < nb; i++) begin
      total++;
      if (obs_data[b0+i] !== exp_data[i] || obs_dst[b0+i] !== exp_dst[i]) begin
        bad++; $display("FAIL grid_beat%0d: got %h/%h want %h/%h", i, obs_data[b0+i], obs_dst[b0+i], exp_data[i], exp_dst[i]);
      end
      if (i > 0) begin
        gap  = obs_cyc[b0+i] - obs_cyc[b0+i-1];
        want = (exp_cell[i] == exp_cell[i-1]) ? 1 : 4;
        total++; if (gap != want) begin bad++; $display("FAIL grid_gap%0d: got %0d want %0d", i, gap, want); end
      end
    end
    for (int c = 0; c < NCELL; c++) obs_cnt[c] = 0;
    for (int i = b0; i < obs_dst.size(); i++)
      if (cell_of(obs_dst[i]) >= 0) obs_cnt[cell_of(obs_dst[i])]++;
    for (int c = 0; c < NCELL; c++) begin
      total++; if (obs_cnt[c] != exp_cnt[c]) begin bad++; $display("FAIL grid_cache%0d: got %0d want %0d", c, obs_cnt[c], exp_cnt[c]); end
    end
    total++; if (done_n - d0 != 1) begin bad++; $display("FAIL grid_done: got %0d want 1", done_n - d0); end
    total++; if (viol != v0) begin bad++; $display("FAIL grid_bus_rules: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_clamp_restart();
    int b0, d0, v0, r13, nb;
    logic [DW-1:0] w;
    bit to;
    fill_cells(0, 3);
    w = {$urandom, $urandom, $urandom};
    w[7:0] = 8'd250;
    mem[13][0] = w;  // cell (2,2,2)
    for (int k = 1; k <= 250; k++) mem[13][k] = {$urandom, $urandom, $urandom};
    build_model();
    b0 = obs_data.size(); d0 = done_n; v0 = viol; r13 = rd_cnt[13];
    run_sweep(40, 1'b1, to);
    nb = obs_data.size() - b0;
    total++; if (to) begin bad++; $display("FAIL clamp_timeout: done not seen within budget"); end
    total++; if (rd_cnt[13] - r13 != CAP) begin bad++; $display("FAIL clamp_reads: got %0d want %0d", rd_cnt[13] - r13, CAP); end
    total++; if (nb != exp_data.size()) begin bad++; $display("FAIL clamp_count: got %0d want %0d", nb, exp_data.size()); end
    for (int i = 0; i < exp_data.size() && i < nb; i++) begin
      total++;
      if (obs_data[b0+i] !== exp_data[i] || obs_dst[b0+i] !== exp_dst[i]) begin
        bad++; $display("FAIL clamp_beat%0d: got %h/%h want %h/%h", i, obs_data[b0+i], obs_dst[b0+i], exp_data[i], exp_dst[i]);
      end
    end
    total++; if (done_n - d0 != 1) begin bad++; $display("FAIL clamp_done: got %0d want 1", done_n - d0); end
    total++; if (out_motion_update_enable !== 1'b0) begin bad++; $display("FAIL start_on_done: enable got %b want 0", out_motion_update_enable); end
    total++; if (viol != v0) begin bad++; $display("FAIL clamp_bus_rules: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_reset_mid();
    int b0, d0, v0, nb;
    bit to, found;
    fill_cells(1, 6);
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge clk);
      if (out_rden && out_read_address != '0) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL midreset_reach: no particle read seen within budget"); end
    #1 rst = 1'b1;
    #1;
    total++; if (out_motion_update_enable !== 1'b0 || out_rden !== 1'b0 || out_done !== 1'b0 || out_data_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_ctrl: en=%b rden=%b done=%b valid=%b want all 0", out_motion_update_enable, out_rden, out_done, out_data_valid);
    end
    total++; if (out_read_address !== '0 || out_read_cell_id !== '0 || out_data !== '0 || out_data_dst_cell !== '0) begin
      bad++; $display("FAIL midreset_data: addr=%h cell=%h data=%h dst=%h want all 0", out_read_address, out_read_cell_id, out_data, out_data_dst_cell);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fill_cells(0, 6);
    build_model();
    b0 = obs_data.size(); d0 = done_n; v0 = viol;
    run_sweep(0, 1'b0, to);
    nb = obs_data.size() - b0;
    total++; if (to) begin bad++; $display("FAIL midreset_timeout: done not seen within budget"); end
    total++; if (nb != exp_data.size()) begin bad++; $display("FAIL midreset_count: got %0d want %0d", nb, exp_data.size()); end
    for (int i = 0; i < exp_data.size() && i < nb; i++) begin
      total++;
      if (obs_data[b0+i] !== exp_data[i] || obs_dst[b0+i] !== exp_dst[i]) begin
        bad++; $display("FAIL midreset_beat%0d: got %h/%h want %h/%h", i, obs_data[b0+i], obs_dst[b0+i], exp_data[i], exp_dst[i]);
      end
    end
    total++; if (done_n - d0 != 1) begin bad++; $display("FAIL midreset_done: got %0d want 1", done_n - d0); end
    total++; if (viol != v0) begin bad++; $display("FAIL midreset_bus_rules: got %0d violations want 0", viol - v0); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_basic();
    test_wrap();
    test_empty_grid();
    test_full_grid();
    test_clamp_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motion_update_broadcaster.md
Name: motion_update_broadcaster

Overview:
- Transmitting end of the motion-update broadcast bus that the per-cell double-buffered position caches receive.
- Walks every cell in x, y, z order; reads the particle count and then each particle position from that cell's active buffer; computes each particle's destination cell; broadcasts {data, dst_cell, valid} to all caches.
- Holds motion_update_enable high for the whole sweep and pulses done once the caches have committed counts and flipped buffers.
- Sits in RL_LJ_Top between the position-cache array and the top-level motion-update control.

Parameters:
- DATA_WIDTH, 96: particle record {posz, posy, posx}, 3 x POS_WIDTH.
- POS_WIDTH, 32: width of one fixed-point position component.
- FRAC_WIDTH, 28: fractional bits per component; cell index = component >> FRAC_WIDTH.
- ADDR_WIDTH, 8: cache address width; address 0 holds the particle count.
- PARTICLE_NUM, 220: maximum particles per cell; larger counts are clamped to this.
- CELL_ID_WIDTH, 4: width of one cell coordinate.
- CELL_MAX_X, 3 / CELL_MAX_Y, 3 / CELL_MAX_Z, 3: grid size; valid cell indices are 1..CELL_MAX.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep; ignored unless IDLE
- in_particle_info  in  DATA_WIDTH  read data from the selected cache; valid 1 cycle after out_rden
- out_read_cell_id  out  3*CELL_ID_WIDTH  cache select {x, y, z} for the top-level readout mux
- out_read_address  out  ADDR_WIDTH  cache read address
- out_rden  out  1  cache read enable
- out_motion_update_enable  out  1  high for the entire sweep
- out_data  out  DATA_WIDTH  broadcast particle position
- out_data_dst_cell  out  3*CELL_ID_WIDTH  destination {cell_x, cell_y, cell_z}
- out_data_valid  out  1  broadcast qualifier
- out_done  out  1  one-cycle pulse when the sweep is complete

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; cell counters = (1,1,1).
- FSM states and transitions:
  - IDLE: on start, enable goes high and the FSM moves to RD_NUM for cell (1,1,1).
  - RD_NUM: drive address 0 with rden = 1; go to WAIT_NUM.
  - WAIT_NUM: latch count = min(in_particle_info[ADDR_WIDTH-1:0], PARTICLE_NUM). If count = 0, go to NEXT_CELL. Otherwise set k = 1 and go to RD_PART.
  - RD_PART: one read per cycle at address k, k = 1..count, rden = 1. After issuing k = count, go to NEXT_CELL.
  - NEXT_CELL: advance z fastest, then y, then x. After (CELL_MAX_X, CELL_MAX_Y, CELL_MAX_Z), go to DRAIN; otherwise go to RD_NUM.
  - DRAIN: wait for the broadcast pipeline to empty, deassert enable, wait 3 cycles, pulse out_done, return to IDLE.
- Broadcast pipeline:
  - Read issued at cycle t; data returns at t+1; out_data, out_data_dst_cell and out_data_valid are registered at t+2.
  - Throughput is one particle per cycle within a cell.
  - Overhead per cell is 3 cycles (RD_NUM, WAIT_NUM, NEXT_CELL).
- Destination cell, per axis:
  - idx = (pos >> FRAC_WIDTH) truncated to CELL_ID_WIDTH bits.
  - If idx = 0, use CELL_MAX (periodic wrap low).
  - If idx > CELL_MAX, use 1 (periodic wrap high).
  - Otherwise use idx.
- Bus rules:
  - When out_data_valid = 0, out_data and out_data_dst_cell are 0.
  - Enable rises at least 1 cycle before the first valid and falls no earlier than 1 cycle after the last valid. This guarantees every cache captures every particle and then writes its count.
- out_read_cell_id holds the current cell through RD_NUM, WAIT_NUM and RD_PART.
- start while not IDLE is ignored; a start on the same cycle as the out_done pulse is also ignored.
- A sweep over an all-empty grid still produces the enable window and the out_done pulse, with zero valids.
- Reset mid-sweep: all outputs drop to 0 asynchronously. The caches see enable fall, so the top level must re-initialise them.

Test Plan:
- Only cell (1,1,1) is populated, count = 2, positions posx = 0x1800_0000 and posx = 0x2000_0000 (y = z = 0x1000_0000) -> two consecutive valids with dst {1,1,1} and {2,1,1}; the caches record 1 particle each; out_done pulses 3 cycles after enable falls.
- Cell (1,1,2) has count = 0 -> no reads at addresses 1+ for that cell; the FSM passes straight to (1,1,3) with no valid pulses.
- Component index 0 (pos = 0x0800_0000) and index 4 (pos = 0x4000_0000) -> dst coordinate 3 and 1 respectively.
- Full 3x3x3 grid with 5 particles per cell -> 135 valids in x-major/z-fastest order; each cache ends with the correct count; out_done pulses once.
- start pulsed mid-sweep, and cache count = 250 -> the second start is ignored; the count is clamped so exactly 220 reads are issued for that cell.
- Assert rst during RD_PART -> all outputs read 0 immediately; after release, a new start performs a clean full sweep.
